hazard_log_packer: RTL and testbench

Collects hazard events from the hazard detection unit one per cycle and packs them into the 64-bit hazard log word consumed by the hazard display/decoder block. Each event becomes an 8-bit record; eight records form one frame, which is emitted with a valid/ready handshake. A flush request emits partially filled frames. A one-frame output register decouples filling from a stalled consumer.

---
 rtl/hazard_log_packer.sv | 81 ++++++++
 tb/tb_hazard_log_packer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/hazard_log_packer.sv
// Packs 8-bit hazard records into 64-bit frames, MSB slot first.
// A single output register holds one frame so that filling can continue while the consumer stalls.
module hazard_log_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        haz_valid,
  input  logic [2:0]  haz_dst,
  input  logic [2:0]  haz_src,
  input  logic [1:0]  haz_sh,
  input  logic        flush,
  output logic [63:0] hazard_mem,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [3:0]  fill_level,
  output logic [7:0]  drop_cnt
);

  logic [63:0] r_buf;
  logic [3:0]  r_cnt;
  logic        r_flushPend;
  logic [63:0] r_mem;
  logic        r_memValid;
  logic [7:0]  r_drop;

  logic        w_full;
  logic        w_xfer;
  logic        w_event;
  logic        w_accept;
  logic [2:0]  w_slot;
  logic [7:0]  w_rec;
  logic [63:0] w_recPos;
  logic [63:0] w_base;
  logic [63:0] w_nextBuf;
  logic [3:0]  w_nextCnt;
  logic [63:0] w_mask;

  // When a frame leaves on this edge, the incoming event lands in slot 0 of the emptied buffer.
  always_comb begin
    w_full    = (r_cnt == 4'd8);
    w_xfer    = (w_full || r_flushPend) && (!r_memValid || mem_ready);
    w_event   = haz_valid && (haz_dst != haz_src);
    w_accept  = w_event && (!w_full || w_xfer);
    w_slot    = w_xfer ? 3'd0 : r_cnt[2:0];
    w_rec     = {haz_dst, haz_src, haz_sh};
    w_recPos  = {w_rec, 56'h0} >> {w_slot, 3'b000};
    w_base    = w_xfer ? 64'h0 : r_buf;
    w_nextBuf = w_accept ? (w_base | w_recPos) : w_base;
    w_nextCnt = w_xfer ? {3'b000, w_accept} : (r_cnt + {3'b000, w_accept});
    w_mask    = ~({64{1'b1}} >> {r_cnt, 3'b000});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf       <= 64'h0;
      r_cnt       <= 4'd0;
      r_flushPend <= 1'b0;
      r_mem       <= 64'h0;
      r_memValid  <= 1'b0;
      r_drop      <= 8'd0;
    end else begin
      r_buf <= w_nextBuf;
      r_cnt <= w_nextCnt;
      if (w_xfer) begin
        r_mem       <= r_buf & w_mask;
        r_memValid  <= 1'b1;
        // A flush arriving with a transfer applies to the record entering the fresh buffer.
        r_flushPend <= flush && w_accept;
      end else begin
        if (mem_ready) r_memValid <= 1'b0;
        if (flush && (r_cnt != 4'd0)) r_flushPend <= 1'b1;
      end
      if (w_event && !w_accept && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
    end
  end

  assign hazard_mem = r_mem;
  assign mem_valid  = r_memValid;
  assign fill_level = r_cnt;
  assign drop_cnt   = r_drop;

endmodule

// File: tb/tb_hazard_log_packer.sv
// Directed bench for hazard_log_packer: frames are queued when their last record is issued
// and a monitor compares them at each consumer handshake.
module tb_hazard_log_packer;

  logic        clk;
  logic        rst_n;
  logic        haz_valid;
  logic [2:0]  haz_dst;
  logic [2:0]  haz_src;
  logic [1:0]  haz_sh;
  logic        flush;
  logic [63:0] hazard_mem;
  logic        mem_valid;
  logic        mem_ready;
  logic [3:0]  fill_level;
  logic [7:0]  drop_cnt;

  int passCount = 0;
  int checkCount = 0;
  logic [63:0] expQ[$];

  hazard_log_packer dut (
    .clk(clk), .rst_n(rst_n), .haz_valid(haz_valid), .haz_dst(haz_dst),
    .haz_src(haz_src), .haz_sh(haz_sh), .flush(flush), .hazard_mem(hazard_mem),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .fill_level(fill_level),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  // Inputs change 1 time unit after the edge; flush and haz_valid are single-cycle.
  task automatic applyStimulus(input logic v, input logic [2:0] d, input logic [2:0] s,
                               input logic [1:0] sh, input logic fl, input logic rdy);
    haz_valid = v;
    haz_dst   = d;
    haz_src   = s;
    haz_sh    = sh;
    flush     = fl;
    mem_ready = rdy;
    @(posedge clk);
    #1;
    haz_valid = 1'b0;
    flush     = 1'b0;
  endtask

  // Monitor: a handshake on the coming edge must deliver the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n && mem_valid && mem_ready) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_frame: got %h expected none", hazard_mem);
      end else begin
        checkOutput("frame", hazard_mem, expQ.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0; haz_valid = 1'b0; haz_dst = 3'd0; haz_src = 3'd0;
    haz_sh = 2'd0; flush = 1'b0; mem_ready = 1'b1;
    #3;
    checkOutput("reset_mem", hazard_mem, 64'h0);
    checkOutput("reset_valid", {63'h0, mem_valid}, 64'h0);
    checkOutput("reset_fill", {60'h0, fill_level}, 64'h0);
    checkOutput("reset_drop", {56'h0, drop_cnt}, 64'h0);
    #9 rst_n = 1'b1;

    $display("[TB] eight records, consumer ready");
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) expQ.push_back(64'h2929292929292929);
      applyStimulus(1'b1, 3'd1, 3'd2, 2'd1, 1'b0, 1'b1);
      checkOutput("fill_count", {60'h0, fill_level}, 64'(i));
    end
    applyStimulus(1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1);
    checkOutput("full_valid", {63'h0, mem_valid}, 64'h1);
    checkOutput("full_mem", hazard_mem, 64'h2929292929292929);
    checkOutput("full_fill", {60'h0, fill_level}, 64'h0);
    applyStimulus(1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1);
    checkOutput("full_consumed", {63'h0, mem_valid}, 64'h0);

    $display("[TB] partial frame flush");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'd1, 3'd2, 2'd1, 1'b0, 1'b1);
    expQ.push_back(64'h2929290000000000);
    applyStimulus(1'b0, 3'd0, 3'd0, 2'd0, 1'b1, 1'b1);
    checkOutput("flush_wait_valid", {63'h0, mem_valid}, 64'h0);
    applyStimulus(1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1);
    checkOutput("flush_valid", {63'h0, mem_valid}, 64'h1);
    checkOutput("flush_mem", hazard_mem, 64'h2929290000000000);
    applyStimulus(1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1);

    $display("[TB] backpressure with 17 events");
    for (int i = 1; i <= 17; i++) begin
      if (i == 8) expQ.push_back(64'h5757575757575757);
      if (i == 16) expQ.push_back(64'hC6C6C6C6C6C6C6C6);
      if (i <= 8) applyStimulus(1'b1, 3'd2, 3'd5, 2'd3, 1'b0, 1'b0);
      else if (i <= 16) applyStimulus(1'b1, 3'd6, 3'd1, 2'd2, 1'b0, 1'b0);
      else applyStimulus(1'b1, 3'd7, 3'd0, 2'd0, 1'b0, 1'b0);
      if (i == 12) checkOutput("stall_hold_mem", hazard_mem, 64'h5757575757575757);
    end
    checkOutput("stall_valid", {63'h0, mem_valid}, 64'h1);
    checkOutput("stall_mem", hazard_mem, 64'h5757575757575757);
    checkOutput("stall_fill", {60'h0, fill_level}, 64'h8);
    checkOutput("stall_drop", {56'h0, drop_cnt}, 64'h1);
    applyStimulus(1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1);
    checkOutput("b2b_valid", {63'h0, mem_valid}, 64'h1);
    checkOutput("b2b_mem", hazard_mem, 64'hC6C6C6C6C6C6C6C6);
    checkOutput("b2b_fill", {60'h0, fill_level}, 64'h0);
    applyStimulus(1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1);
    checkOutput("b2b_consumed", {63'h0, mem_valid}, 64'h0);

    $display("[TB] non-hazard event and empty flush");
    applyStimulus(1'b1, 3'd3, 3'd3, 2'd1, 1'b0, 1'b1);
    checkOutput("same_tag_fill", {60'h0, fill_level}, 64'h0);
    checkOutput("same_tag_drop", {56'h0, drop_cnt}, 64'h1);
    applyStimulus(1'b0, 3'd0, 3'd0, 2'd0, 1'b1, 1'b1);
    checkOutput("empty_flush_valid", {63'h0, mem_valid}, 64'h0);
    applyStimulus(1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1);
    checkOutput("empty_flush_valid2", {63'h0, mem_valid}, 64'h0);

    $display("[TB] drop counter saturation");
    for (int i = 0; i < 316; i++) begin
      if (i == 7 || i == 15) expQ.push_back(64'h2929292929292929);
      applyStimulus(1'b1, 3'd1, 3'd2, 2'd1, 1'b0, 1'b0);
    end
    checkOutput("sat_drop", {56'h0, drop_cnt}, 64'hFF);
    checkOutput("sat_fill", {60'h0, fill_level}, 64'h8);

    $display("[TB] asynchronous reset mid-frame");
    applyStimulus(1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 3'd1, 3'd2, 2'd1, 1'b0, 1'b0);
    checkOutput("pre_reset_fill", {60'h0, fill_level}, 64'h5);
    checkOutput("pre_reset_valid", {63'h0, mem_valid}, 64'h1);
    #2 rst_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("areset_mem", hazard_mem, 64'h0);
    checkOutput("areset_valid", {63'h0, mem_valid}, 64'h0);
    checkOutput("areset_fill", {60'h0, fill_level}, 64'h0);
    checkOutput("areset_drop", {56'h0, drop_cnt}, 64'h0);
    #1 rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) expQ.push_back(64'h8181818181818181);
      applyStimulus(1'b1, 3'd4, 3'd0, 2'd1, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1);
    checkOutput("post_reset_mem", hazard_mem, 64'h8181818181818181);
    applyStimulus(1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1);
    checkOutput("queue_empty", 64'(expQ.size()), 64'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
